// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: register-mapped controller for one bank of N bidirectional pad cells.
// Define GPIO_DEBOUNCE_EN to add the prescaled per-channel input debouncer and DB_DIV register.
module gpio_pad_bank #(
  parameter int N        = 16,
  parameter int DB_CNT   = 4,
  parameter int DB_DIV_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic          cfg_re,
  input  logic [3:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  output logic [31:0]   cfg_rdata,
  output logic          irq,
  output logic [N-1:0]  pad_a,
  output logic [N-1:0]  pad_nen,
  output logic [N-1:0]  pad_pen,
  output logic [N-1:0]  pad_pu,
  output logic [N-1:0]  pad_pd,
  output logic [N-1:0]  pad_sonof,
  output logic [N-1:0]  pad_conof,
  input  logic [N-1:0]  pad_d
);

  localparam logic [3:0] A_DOUT     = 4'h0;
  localparam logic [3:0] A_OE       = 4'h1;
  localparam logic [3:0] A_PULL_EN  = 4'h2;
  localparam logic [3:0] A_PULL_SEL = 4'h3;
  localparam logic [3:0] A_SCHMITT  = 4'h4;
  localparam logic [3:0] A_DIN      = 4'h5;
  localparam logic [3:0] A_IE_RISE  = 4'h6;
  localparam logic [3:0] A_IE_FALL  = 4'h7;
  localparam logic [3:0] A_IRQ_STAT = 4'h8;
  localparam logic [3:0] A_DB_DIV   = 4'h9;
  localparam logic [3:0] A_CONOF    = 4'hA;

  logic [N-1:0] dout_q, oe_q, pull_en_q, pull_sel_q, schmitt_q;
  logic [N-1:0] ie_rise_q, ie_fall_q, irq_stat_q, conof_q;
  logic [N-1:0] dout_d, oe_d, pull_en_d, pull_sel_d, schmitt_d;
  logic [N-1:0] ie_rise_d, ie_fall_d, irq_stat_d, conof_d;
  logic [N-1:0] wdata_n, w1c, irq_set;
  logic [N-1:0] sync1_q, sync2_q, din_q, din_prev_q;
  logic [31:0]  rd_mux;
  logic         unused_bits;

  assign wdata_n     = cfg_wdata[N-1:0];
  assign unused_bits = ^{cfg_wdata, 1'(DB_CNT), 1'(DB_DIV_W)};

  always_comb begin
    dout_d     = dout_q;
    oe_d       = oe_q;
    pull_en_d  = pull_en_q;
    pull_sel_d = pull_sel_q;
    schmitt_d  = schmitt_q;
    ie_rise_d  = ie_rise_q;
    ie_fall_d  = ie_fall_q;
    conof_d    = conof_q;
    if (cfg_we) begin
      case (cfg_addr)
        A_DOUT:     dout_d     = wdata_n;
        A_OE:       oe_d       = wdata_n;
        A_PULL_EN:  pull_en_d  = wdata_n;
        A_PULL_SEL: pull_sel_d = wdata_n;
        A_SCHMITT:  schmitt_d  = wdata_n;
        A_IE_RISE:  ie_rise_d  = wdata_n;
        A_IE_FALL:  ie_fall_d  = wdata_n;
        A_CONOF:    conof_d    = wdata_n;
        default:    begin end
      endcase
    end
  end

  // A new edge in the same cycle as a W1C keeps the bit set.
  assign w1c        = (cfg_we && cfg_addr == A_IRQ_STAT) ? wdata_n : '0;
  assign irq_set    = (din_q & ~din_prev_q & ie_rise_q) | (~din_q & din_prev_q & ie_fall_q);
  assign irq_stat_d = (irq_stat_q & ~w1c) | irq_set;

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [7:0] CNT_MAX = 8'(DB_CNT);

  logic [DB_DIV_W-1:0] db_div_q, presc_q;
  logic [7:0]          db_cnt_q [N];
  logic                tick;

  assign tick = (presc_q == db_div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_div_q <= '0;
      presc_q  <= '0;
    end else if (cfg_we && cfg_addr == A_DB_DIV) begin
      db_div_q <= cfg_wdata[DB_DIV_W-1:0];
      presc_q  <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // The first tick after a change may be partial, so DB_CNT whole tick periods
  // of stability are required: the update happens on the tick after the count reaches DB_CNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= '0;
      for (int i = 0; i < N; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2_q[i] == din_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (tick) begin
          if (db_cnt_q[i] == CNT_MAX) begin
            din_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
          end
        end
      end
    end
  end
`else
  assign din_q = sync2_q;
`endif

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      A_DOUT:     rd_mux[N-1:0] = dout_q;
      A_OE:       rd_mux[N-1:0] = oe_q;
      A_PULL_EN:  rd_mux[N-1:0] = pull_en_q;
      A_PULL_SEL: rd_mux[N-1:0] = pull_sel_q;
      A_SCHMITT:  rd_mux[N-1:0] = schmitt_q;
      A_DIN:      rd_mux[N-1:0] = din_q;
      A_IE_RISE:  rd_mux[N-1:0] = ie_rise_q;
      A_IE_FALL:  rd_mux[N-1:0] = ie_fall_q;
      A_IRQ_STAT: rd_mux[N-1:0] = irq_stat_q;
`ifdef GPIO_DEBOUNCE_EN
      A_DB_DIV:   rd_mux[DB_DIV_W-1:0] = db_div_q;
`endif
      A_CONOF:    rd_mux[N-1:0] = conof_q;
      default:    rd_mux = '0;
    endcase
  end

  // Pad pins get their own flops loaded from next-state values, so a write shows
  // on the pins at the sampling edge and the decoded pulls never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      oe_q       <= '0;
      pull_en_q  <= '0;
      pull_sel_q <= '0;
      schmitt_q  <= '0;
      ie_rise_q  <= '0;
      ie_fall_q  <= '0;
      irq_stat_q <= '0;
      conof_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      din_prev_q <= '0;
      pad_a      <= '0;
      pad_nen    <= '1;
      pad_pen    <= '0;
      pad_pu     <= '0;
      pad_pd     <= '0;
      pad_sonof  <= '0;
      pad_conof  <= '0;
      irq        <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      pull_en_q  <= pull_en_d;
      pull_sel_q <= pull_sel_d;
      schmitt_q  <= schmitt_d;
      ie_rise_q  <= ie_rise_d;
      ie_fall_q  <= ie_fall_d;
      irq_stat_q <= irq_stat_d;
      conof_q    <= conof_d;
      sync1_q    <= pad_d;
      sync2_q    <= sync1_q;
      din_prev_q <= din_q;
      pad_a      <= dout_d;
      pad_nen    <= ~oe_d;
      pad_pen    <= pull_en_d;
      pad_pu     <= pull_en_d & pull_sel_d;
      pad_pd     <= pull_en_d & ~pull_sel_d;
      pad_sonof  <= schmitt_d;
      pad_conof  <= conof_d;
      irq        <= |irq_stat_d;
      if (cfg_re) cfg_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb_gpio_pad_bank: randomized register/pad traffic against a cycle-level reference model,
// plus directed latency, collision, debounce and asynchronous-reset checks.
module tb_gpio_pad_bank;

  localparam int N = 16;
  localparam logic [31:0] NMASK = 32'h0000_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_re = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          irq;
  logic [N-1:0]  pad_a, pad_nen, pad_pen, pad_pu, pad_pd, pad_sonof, pad_conof;
  logic [N-1:0]  pad_d = '0;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b1;

  // Reference state: register file by address, pad_d history (newest first), status, read data.
  logic [31:0]  m_reg [16];
  logic [N-1:0] m_hist [3];
  logic [N-1:0] m_stat;
  logic [31:0]  m_rdata;

  gpio_pad_bank #(.N(N), .DB_CNT(4), .DB_DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq(irq), .pad_a(pad_a), .pad_nen(pad_nen),
    .pad_pen(pad_pen), .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_sonof(pad_sonof),
    .pad_conof(pad_conof), .pad_d(pad_d)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_stat  = '0;
    m_rdata = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    case (a)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA: return m_reg[a];
      4'h5: return 32'(m_hist[1]);
      4'h8: return 32'(m_stat);
`ifdef GPIO_DEBOUNCE_EN
      4'h9: return m_reg[9];
`endif
      default: return 32'h0;
    endcase
  endfunction

  // DIN is pad_d two samples late; an edge shows in status one sample after that.
  task automatic modelEdge();
    logic [N-1:0] din_old, prev_old, set, w1c;
    din_old  = m_hist[1];
    prev_old = m_hist[2];
    if (cfg_re) m_rdata = modelRead(cfg_addr);
    set = (din_old & ~prev_old & m_reg[6][N-1:0]) | (~din_old & prev_old & m_reg[7][N-1:0]);
    w1c = (cfg_we && cfg_addr == 4'h8) ? cfg_wdata[N-1:0] : '0;
    m_stat = (m_stat & ~w1c) | set;
    if (cfg_we) begin
      case (cfg_addr)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hA: m_reg[cfg_addr] = cfg_wdata & NMASK;
`ifdef GPIO_DEBOUNCE_EN
        4'h9: m_reg[9] = cfg_wdata & NMASK;
`endif
        default: begin end
      endcase
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pad_d;
  endtask

  task automatic modelCompare();
    logic [N-1:0] e_nen, e_pu, e_pd;
    e_nen = ~m_reg[1][N-1:0];
    e_pu  = m_reg[2][N-1:0] & m_reg[3][N-1:0];
    e_pd  = m_reg[2][N-1:0] & ~m_reg[3][N-1:0];
    checkOutput("pad_a", 32'(pad_a), m_reg[0]);
    checkOutput("pad_nen", 32'(pad_nen), 32'(e_nen));
    checkOutput("pad_pen", 32'(pad_pen), m_reg[2]);
    checkOutput("pad_pu", 32'(pad_pu), 32'(e_pu));
    checkOutput("pad_pd", 32'(pad_pd), 32'(e_pd));
    checkOutput("pad_sonof", 32'(pad_sonof), m_reg[4]);
    checkOutput("pad_conof", 32'(pad_conof), m_reg[10]);
    checkOutput("irq", 32'(irq), 32'(|m_stat));
    checkOutput("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic [N-1:0] pad);
    cfg_we    = we;
    cfg_re    = re;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    pad_d     = pad;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (model_on) modelCompare();
  endtask

  initial begin
    logic [3:0]   a;
    logic         we, re;
    logic [N-1:0] pv;
    int           first;

    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_pad_nen", 32'(pad_nen), 32'h0000_FFFF);
    checkOutput("rst_pad_a", 32'(pad_a), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_rdata", cfg_rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 4'(i), 32'h0, '0);

    applyStimulus(1'b1, 1'b0, 4'h1, 32'h0000_0003, '0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0001, '0);
    checkOutput("dir_nen", 32'(pad_nen), 32'h0000_FFFC);
    checkOutput("dir_a", 32'(pad_a), 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 4'h2, 32'h0000_00F0, '0);
    applyStimulus(1'b1, 1'b0, 4'h3, 32'hFFFF_0030, '0);
    checkOutput("dir_pen", 32'(pad_pen), 32'h0000_00F0);
    checkOutput("dir_pu", 32'(pad_pu), 32'h0000_0030);
    checkOutput("dir_pd", 32'(pad_pd), 32'h0000_00C0);

`ifndef GPIO_DEBOUNCE_EN
    applyStimulus(1'b1, 1'b0, 4'h6, 32'h1, '0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    checkOutput("lat_k0_irq", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    checkOutput("lat_k1_irq", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    checkOutput("lat_k2_irq", 32'(irq), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h8, 32'h0, 16'h1);
    checkOutput("lat_stat", cfg_rdata, 32'h1);
    applyStimulus(1'b1, 1'b0, 4'h8, 32'h1, 16'h1);
    checkOutput("w1c_irq", 32'(irq), 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    applyStimulus(1'b1, 1'b0, 4'h8, 32'h1, 16'h1);
    checkOutput("collide_irq", 32'(irq), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h8, 32'h0, 16'h1);
    checkOutput("collide_stat", cfg_rdata, 32'h1);
    applyStimulus(1'b1, 1'b0, 4'h8, 32'h1, 16'h1);
    checkOutput("collide_clr_irq", 32'(irq), 32'h0);
`endif

    pv = '0;
    for (int i = 0; i < 300; i++) begin
      a  = 4'($urandom_range(0, 15));
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 1);
`ifndef GPIO_DEBOUNCE_EN
      if ($urandom_range(0, 3) == 0) pv = N'($urandom);
`endif
      applyStimulus(we, re, a, $urandom, pv);
    end

`ifdef GPIO_DEBOUNCE_EN
    model_on = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h6, 32'h4, '0);
    applyStimulus(1'b1, 1'b0, 4'h7, 32'h0, '0);
    applyStimulus(1'b1, 1'b0, 4'h8, 32'hFFFF, '0);
    applyStimulus(1'b1, 1'b0, 4'h9, 32'h3, '0);
    repeat (15) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h4);
    repeat (30) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h0);
    checkOutput("db_glitch_irq", 32'(irq), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h5, 32'h0, 16'h0);
    checkOutput("db_glitch_din", cfg_rdata, 32'h0);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h4);
      if (irq && first < 0) first = i;
    end
    checkOutput("db_hold_latency_ok", 32'(first >= 19 && first <= 23), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h5, 32'h0, 16'h4);
    checkOutput("db_hold_din", cfg_rdata, 32'h4);
    applyStimulus(1'b0, 1'b1, 4'h9, 32'h0, 16'h4);
    checkOutput("db_div_read", cfg_rdata, 32'h3);
    pv = 16'h4;
`else
    applyStimulus(1'b1, 1'b0, 4'h6, 32'h1, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h0);
    repeat (4) applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 16'h1);
    pv = 16'h1;
`endif
    applyStimulus(1'b1, 1'b0, 4'h1, 32'hFFFF, pv);
    checkOutput("pre_rst_nen", 32'(pad_nen), 32'h0);
    checkOutput("pre_rst_irq", 32'(irq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_nen", 32'(pad_nen), 32'h0000_FFFF);
    checkOutput("async_rst_irq", 32'(irq), 32'h0);
    checkOutput("async_rst_a", 32'(pad_a), 32'h0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h0, '0);
    applyStimulus(1'b0, 1'b1, 4'h8, 32'h0, '0);
    checkOutput("post_rst_stat", cfg_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_pad_bank.md
# gpio_pad_bank

Parametrised GPIO controller driving a bank of N bidirectional pad cells (PLBI*/PSBI* family) from a register port. It owns every pad control pin: output data, active-low output enable, pull enable and pull direction, Schmitt and CONOF selects. On the input side it synchronises the pad data, optionally debounces it, and raises a level interrupt on selectable rising and falling edges. It sits between the core register bus and the padring, one instance per pad bank.

## Interface
- N, 16, number of pad channels (1..32)
- DB_CNT, 4, debounce ticks an input must stay stable before DIN updates (1..255)
- DB_DIV_W, 16, width of the debounce prescaler register

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  register write strobe
- cfg_re  in  1  register read strobe
- cfg_addr  in  4  register address
- cfg_wdata  in  32  write data; bits above N ignored
- cfg_rdata  out  32  read data, registered; bits above N read 0
- irq  out  1  OR of unmasked IRQ_STAT bits
- pad_a  out  N  to pad A (output data)
- pad_nen  out  N  to pad NEN (0 = drive)
- pad_pen / pad_pu / pad_pd  out  N each  to pad pull pins
- pad_sonof / pad_conof  out  N each  to pad SONOF / CONOF
- pad_d  in  N  from pad D, asynchronous

## Operation
- Register map (word address):
  - 0x0 DOUT rw
  - 0x1 OE rw
  - 0x2 PULL_EN rw
  - 0x3 PULL_SEL rw (1 = up)
  - 0x4 SCHMITT rw
  - 0x5 DIN ro
  - 0x6 IE_RISE rw
  - 0x7 IE_FALL rw
  - 0x8 IRQ_STAT (write 1 to clear)
  - 0x9 DB_DIV rw
  - 0xA CONOF rw
  - Other addresses read 0; writes to them are ignored.
- Pad control outputs are driven from flops:
  - pad_a = DOUT
  - pad_nen = ~OE
  - pad_pen = PULL_EN
  - pad_pu = PULL_EN & PULL_SEL
  - pad_pd = PULL_EN & ~PULL_SEL
  - pad_sonof = SCHMITT
  - pad_conof = CONOF
- Input path: pad_d passes through a 2-flop synchroniser (sync2), then the debouncer, then din_q. DIN reads din_q.
- Edge detect compares din_q with din_prev (the previous din_q). A rising edge with IE_RISE set, or a falling edge with IE_FALL set, sets the channel's IRQ_STAT bit.
- irq = |IRQ_STAT. It is driven from flops, with no added combinational path from pad_d.
- Clearing IE bits does not clear IRQ_STAT bits that are already set.
- A W1C write and a set on the same cycle for the same bit: the set wins.

## Timing
- Reset values: all registers 0, so every pad is tri-stated (pad_nen all 1) with pulls off.
  - pad_a, pad_pen, pad_pu, pad_pd, pad_sonof, pad_conof all 0.
  - din_q, din_prev, IRQ_STAT 0; irq 0; cfg_rdata 0.
  - Debounce counters and prescaler 0.
- Write: takes effect on the pad pins at the clk edge that samples cfg_we.
- Read: cfg_rdata is valid the cycle after cfg_re, and holds until the next read.
- Simultaneous cfg_we and cfg_re to the same address return the old value.
- Input latency, no debounce: pad_d changes before edge k. sync2 updates at k+1, din_q at k+1, IRQ_STAT at k+2, irq high after k+2.
- Reset mid-operation: asynchronous. All state clears immediately and pads tri-state with no glitch to drive-high.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - A prescaler counts 0..DB_DIV and emits one tick per DB_DIV+1 clocks.
  - Per channel, while sync2 != din_q the counter increments on each tick; it resets to 0 whenever sync2 == din_q.
  - When the counter reaches DB_CNT, din_q takes sync2 and the counter returns to 0.
  - A glitch shorter than DB_CNT ticks never reaches DIN.
  - A DB_DIV write restarts the prescaler at 0.
- GPIO_DEBOUNCE_EN undefined:
  - din_q = sync2 (a pure register, no debounce).
  - The DB_DIV register is absent and reads 0.
  - The prescaler and counters are not synthesised.

## Test plan
- Reset, then read all registers: every register reads 0 and pad_nen = all 1s. Write OE=0x0003, DOUT=0x0001: next cycle pad_nen=0xFFFC, pad_a=0x0001.
- PULL_EN=0x00F0, PULL_SEL=0x0030: pad_pen=0x00F0, pad_pu=0x0030, pad_pd=0x00C0.
- Debounce off, IE_RISE=0x1: pad_d[0] rises before edge k, irq rises after edge k+2 and IRQ_STAT reads 0x1. W1C 0x1 drops irq the next cycle.
- Set and W1C collide: a W1C to bit 0 on the same cycle a new rising edge sets it leaves IRQ_STAT[0]=1 and irq stays high.
- Debounce on, DB_DIV=3, DB_CNT=4:
  - A 15-cycle pulse on pad_d[2] leaves DIN[2]=0 and no IRQ.
  - A held level updates DIN[2] within 2+16..2+20 cycles.
- Assert rst_n low while pads drive with IRQ pending: pad_nen returns to all 1s and irq to 0 asynchronously, before the next clk edge.
